// File: rtl/gmii_frame_source_pkg.sv
// rtl/gmii_frame_source_pkg.sv - shared constants, state encoding and helpers for the GMII frame source
package gmii_frame_source_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          PREAMBLE_LEN  = 7;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        PAD,
        FCS,
        DROP,
        IFG
    } state_t;

    // A programmed gap of zero still leaves one idle cycle so frames never abut.
    function automatic logic [7:0] ifg_len(input logic [7:0] cfg);
        return (cfg == 8'd0) ? 8'd1 : cfg;
    endfunction

endpackage

// File: rtl/gmii_frame_source_if.sv
// rtl/gmii_frame_source_if.sv - 8-bit payload stream bundle feeding the GMII frame source
// Signals: tdata (payload byte), tvalid, tready, tlast (last byte of frame),
//          tuser (with tlast: emit that byte with an error flag).
// master: stream producer; slave: the frame source.
interface gmii_frame_source_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/gmii_frame_source_lfsr.sv
// rtl/gmii_frame_source_lfsr.sv - combinational Galois LFSR step, configured here as reflected CRC-32
// Ports: state_in  - current LFSR/CRC state
//        data_in   - data bits absorbed this cycle, LSB first
//        state_out - state after absorbing all DATA_WIDTH bits
module gmii_frame_source_lfsr
    import gmii_frame_source_pkg::*;
#(
    parameter int                      LFSR_WIDTH = 32,
    parameter logic [LFSR_WIDTH-1:0]   LFSR_POLY  = CRC32_POLY,
    parameter int                      DATA_WIDTH = 8
) (
    input  logic [LFSR_WIDTH-1:0] state_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [LFSR_WIDTH-1:0] state_out
);

    // Reflected form: shift right, feedback taken from bit 0 mixed with the data bit.
    always_comb begin
        state_out = state_in;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (state_out[0] ^ data_in[i]) begin
                state_out = (state_out >> 1) ^ LFSR_POLY;
            end else begin
                state_out = state_out >> 1;
            end
        end
    end

endmodule

// File: rtl/gmii_frame_source.sv
// rtl/gmii_frame_source.sv - PHY-side GMII frame generator driving a MAC receive interface
// Ports: clk, rst (synchronous, active-high)
//        s_axis          - payload stream in (slave modport)
//        gmii_rxd/gmii_rx_dv/gmii_rx_er - GMII byte stream to the MAC
//        cfg_ifg         - idle cycles after FCS (0 behaves as 1), sampled on IFG entry
//        cfg_fcs_corrupt - sampled at frame start, flips bit 0 of the first FCS byte
//        busy            - frame or gap in progress
//        frame_done      - pulse with the last FCS byte
//        error_underflow - pulse with the injected error byte on a mid-frame stall
module gmii_frame_source
    import gmii_frame_source_pkg::*;
#(
    parameter bit ENABLE_PADDING   = 1'b1,
    parameter int MIN_FRAME_LENGTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    gmii_frame_source_if.slave   s_axis,
    output logic [7:0]           gmii_rxd,
    output logic                 gmii_rx_dv,
    output logic                 gmii_rx_er,
    input  logic [7:0]           cfg_ifg,
    input  logic                 cfg_fcs_corrupt,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 error_underflow
);

    localparam logic [15:0] PAD_TARGET = 16'(MIN_FRAME_LENGTH - 4);

    state_t      state;
    logic [2:0]  pre_cnt;
    logic        sfd_now;      // current output cycle carries the SFD
    logic [15:0] byte_cnt;
    logic [15:0] cnt_inc;
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic [7:0]  crc_data;
    logic [1:0]  fcs_idx;
    logic [7:0]  fcs_byte;
    logic [7:0]  ifg_cnt;
    logic        fcs_corrupt;

    always_comb begin
        crc_data = (state == PAD) ? 8'h00 : s_axis.tdata;
        cnt_inc  = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
    end

    always_comb begin
        case (fcs_idx)
            2'd0:    fcs_byte = ~crc[7:0] ^ {7'b0, fcs_corrupt};
            2'd1:    fcs_byte = ~crc[15:8];
            2'd2:    fcs_byte = ~crc[23:16];
            default: fcs_byte = ~crc[31:24];
        endcase
    end

    gmii_frame_source_lfsr #(
        .LFSR_WIDTH (32),
        .LFSR_POLY  (CRC32_POLY),
        .DATA_WIDTH (8)
    ) u_crc (
        .state_in  (crc),
        .data_in   (crc_data),
        .state_out (crc_next)
    );

    // Every output is registered: each edge decides what the link shows next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            pre_cnt         <= '0;
            sfd_now         <= 1'b0;
            byte_cnt        <= '0;
            crc             <= CRC32_INIT;
            fcs_idx         <= '0;
            ifg_cnt         <= '0;
            fcs_corrupt     <= 1'b0;
            gmii_rxd        <= '0;
            gmii_rx_dv      <= 1'b0;
            gmii_rx_er      <= 1'b0;
            s_axis.tready   <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            error_underflow <= 1'b0;
        end else begin
            gmii_rx_er      <= 1'b0;
            frame_done      <= 1'b0;
            error_underflow <= 1'b0;
            case (state)
                IDLE: begin
                    gmii_rxd      <= 8'h00;
                    gmii_rx_dv    <= 1'b0;
                    s_axis.tready <= 1'b0;
                    busy          <= 1'b0;
                    if (s_axis.tvalid) begin
                        state       <= PREAMBLE;
                        pre_cnt     <= '0;
                        fcs_corrupt <= cfg_fcs_corrupt;
                        byte_cnt    <= '0;
                        crc         <= CRC32_INIT;
                        gmii_rxd    <= PREAMBLE_BYTE;
                        gmii_rx_dv  <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                PREAMBLE: begin
                    gmii_rx_dv <= 1'b1;
                    if (pre_cnt == 3'(PREAMBLE_LEN - 1)) begin
                        // SFD goes out while the first payload byte is offered.
                        gmii_rxd      <= SFD_BYTE;
                        s_axis.tready <= 1'b1;
                        sfd_now       <= 1'b1;
                        state         <= PAYLOAD;
                    end else begin
                        gmii_rxd <= PREAMBLE_BYTE;
                        pre_cnt  <= pre_cnt + 3'd1;
                    end
                end
                PAYLOAD: begin
                    sfd_now    <= 1'b0;
                    gmii_rx_dv <= 1'b1;
                    if (s_axis.tvalid && s_axis.tready) begin
                        gmii_rxd   <= s_axis.tdata;
                        gmii_rx_er <= s_axis.tlast && s_axis.tuser;
                        crc        <= crc_next;
                        byte_cnt   <= cnt_inc;
                        if (s_axis.tlast) begin
                            s_axis.tready <= 1'b0;
                            fcs_idx       <= '0;
                            if (ENABLE_PADDING && (cnt_inc < PAD_TARGET)) begin
                                state <= PAD;
                            end else begin
                                state <= FCS;
                            end
                        end
                    end else if (sfd_now) begin
                        // A stall during the SFD cycle is tolerated once: hold the SFD.
                        gmii_rxd <= SFD_BYTE;
                    end else begin
                        gmii_rxd        <= 8'h00;
                        gmii_rx_er      <= 1'b1;
                        error_underflow <= 1'b1;
                        state           <= DROP;
                    end
                end
                PAD: begin
                    gmii_rxd   <= 8'h00;
                    gmii_rx_dv <= 1'b1;
                    crc        <= crc_next;
                    byte_cnt   <= cnt_inc;
                    if (cnt_inc >= PAD_TARGET) begin
                        state <= FCS;
                    end
                end
                FCS: begin
                    gmii_rxd   <= fcs_byte;
                    gmii_rx_dv <= 1'b1;
                    fcs_idx    <= fcs_idx + 2'd1;
                    if (fcs_idx == 2'd3) begin
                        frame_done <= 1'b1;
                        ifg_cnt    <= ifg_len(cfg_ifg);
                        state      <= IFG;
                    end
                end
                DROP: begin
                    gmii_rxd   <= 8'h00;
                    gmii_rx_dv <= 1'b0;
                    if (s_axis.tvalid && s_axis.tready && s_axis.tlast) begin
                        s_axis.tready <= 1'b0;
                        ifg_cnt       <= ifg_len(cfg_ifg);
                        state         <= IFG;
                    end
                end
                IFG: begin
                    gmii_rxd      <= 8'h00;
                    gmii_rx_dv    <= 1'b0;
                    s_axis.tready <= 1'b0;
                    if (ifg_cnt == 8'd0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        ifg_cnt <= ifg_cnt - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_frame_source.sv
// tb/tb_gmii_frame_source.sv - self-checking bench for gmii_frame_source
module tb_gmii_frame_source;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tdata = 8'h00;
    logic       tvalid = 1'b0;
    logic       tlast = 1'b0;
    logic       tuser = 1'b0;
    logic [7:0] cfg_ifg = 8'd12;
    logic       cfg_fcs_corrupt = 1'b0;
    logic       sel = 1'b0;

    always #5 clk = ~clk;

    gmii_frame_source_if if_np();
    gmii_frame_source_if if_p();

    assign if_np.tdata  = tdata;
    assign if_np.tvalid = tvalid;
    assign if_np.tlast  = tlast;
    assign if_np.tuser  = tuser;
    assign if_p.tdata   = tdata;
    assign if_p.tvalid  = tvalid;
    assign if_p.tlast   = tlast;
    assign if_p.tuser   = tuser;

    logic [7:0] np_rxd, p_rxd;
    logic np_dv, np_er, np_busy, np_done, np_uf;
    logic p_dv, p_er, p_busy, p_done, p_uf;

    gmii_frame_source #(.ENABLE_PADDING(1'b0), .MIN_FRAME_LENGTH(64)) u_dut_np (
        .clk(clk), .rst(rst), .s_axis(if_np),
        .gmii_rxd(np_rxd), .gmii_rx_dv(np_dv), .gmii_rx_er(np_er),
        .cfg_ifg(cfg_ifg), .cfg_fcs_corrupt(cfg_fcs_corrupt),
        .busy(np_busy), .frame_done(np_done), .error_underflow(np_uf)
    );

    gmii_frame_source #(.ENABLE_PADDING(1'b1), .MIN_FRAME_LENGTH(64)) u_dut_p (
        .clk(clk), .rst(rst), .s_axis(if_p),
        .gmii_rxd(p_rxd), .gmii_rx_dv(p_dv), .gmii_rx_er(p_er),
        .cfg_ifg(cfg_ifg), .cfg_fcs_corrupt(cfg_fcs_corrupt),
        .busy(p_busy), .frame_done(p_done), .error_underflow(p_uf)
    );

    logic [7:0] m_rxd;
    logic m_dv, m_er, m_busy, m_done, m_uf, m_tready;
    assign m_rxd    = sel ? p_rxd : np_rxd;
    assign m_dv     = sel ? p_dv : np_dv;
    assign m_er     = sel ? p_er : np_er;
    assign m_busy   = sel ? p_busy : np_busy;
    assign m_done   = sel ? p_done : np_done;
    assign m_uf     = sel ? p_uf : np_uf;
    assign m_tready = sel ? if_p.tready : if_np.tready;

    int n_cmp = 0;
    int n_fail = 0;

    // Output monitor on the falling edge.
    logic [7:0] cap_d[$];
    logic       cap_er[$];
    int         gaps[$];
    int         done_cnt, uf_cnt, ifg_meas, low_run, tr_idx;
    logic [7:0] done_byte;
    bit         in_ifg, seen_high;

    always @(negedge clk) begin
        if (m_dv) begin
            if (seen_high && low_run > 0) gaps.push_back(low_run);
            seen_high = 1'b1;
            low_run = 0;
            if (m_tready && tr_idx < 0) tr_idx = cap_d.size();
            cap_d.push_back(m_rxd);
            cap_er.push_back(m_er);
        end else begin
            low_run++;
        end
        if (m_done) begin
            done_cnt++;
            done_byte = m_rxd;
            in_ifg = 1'b1;
            ifg_meas = 0;
        end else if (in_ifg) begin
            if (!m_busy) in_ifg = 1'b0;
            else if (!m_dv) ifg_meas++;
        end
        if (m_uf) uf_cnt++;
    end

    task automatic mon_clear();
        cap_d.delete();
        cap_er.delete();
        gaps.delete();
        done_cnt = 0;
        uf_cnt = 0;
        ifg_meas = 0;
        low_run = 0;
        tr_idx = -1;
        done_byte = 8'h00;
        in_ifg = 1'b0;
        seen_high = 1'b0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_ref(input logic [7:0] q[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tvalid = 1'b0;
        tlast = 1'b0;
        tuser = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        tvalid = 1'b0;
        tlast = 1'b0;
        tuser = 1'b0;
    endtask

    // Offers len bytes base, base+1, ... ; drop_at stalls one cycle before that byte index,
    // abort_at stops driving once that many bytes were accepted.
    task automatic send_frame(input int len, input logic [7:0] base, input bit tuser_last,
                              input int drop_at, input int abort_at);
        int idx = 0;
        int cyc = 0;
        bit dropped = 1'b0;
        while (idx < len) begin
            @(negedge clk);
            cyc++;
            if (cyc > 3000) begin
                check("send_timeout", idx, len);
                tvalid = 1'b0;
                return;
            end
            if (idx == abort_at) begin
                tvalid = 1'b0;
                tlast = 1'b0;
                tuser = 1'b0;
                return;
            end
            if (idx == drop_at && !dropped) begin
                dropped = 1'b1;
                tvalid = 1'b0;
                tlast = 1'b0;
                tuser = 1'b0;
            end else begin
                tvalid = 1'b1;
                tdata = base + 8'(idx);
                tlast = (idx == len - 1);
                tuser = tuser_last && (idx == len - 1);
                if (m_tready) idx++;
            end
        end
    endtask

    typedef struct {
        int          len;
        logic [7:0]  base;
        bit          pad;
        bit          tuser;
        bit          corrupt;
        int          ifg;
        int          exp_dv;
        bit          use_hand;
        logic [31:0] hand_fcs;
    } vec_t;

    vec_t vecs[7];

    task automatic run_frame(input vec_t v, input bit with_reset);
        logic [7:0]  pl[$];
        logic [7:0]  exp_q[$];
        logic [31:0] fcs;
        int cyc, bad, bad_er;
        if (with_reset) do_reset();
        sel = v.pad;
        cfg_ifg = 8'(v.ifg);
        cfg_fcs_corrupt = v.corrupt;
        mon_clear();
        for (int i = 0; i < v.len; i++) pl.push_back(v.base + 8'(i));
        if (v.pad) while (pl.size() < 60) pl.push_back(8'h00);
        fcs = v.use_hand ? v.hand_fcs : (crc_ref(pl) ^ {31'h0, v.corrupt});
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (pl[i]) exp_q.push_back(pl[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);

        send_frame(v.len, v.base, v.tuser, -1, -1);
        idle_inputs();
        cyc = 0;
        while ((done_cnt == 0 || in_ifg || m_busy) && cyc < 3000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("frame_timeout", int'(cyc < 3000), 1);
        check("dv_cycles", cap_d.size(), v.exp_dv);
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < cap_d.size(); i++)
            if (cap_d[i] !== exp_q[i]) bad++;
        check("byte_mismatches", bad, 0);
        bad_er = 0;
        foreach (cap_er[i])
            if (cap_er[i] !== (v.tuser && i == 8 + v.len - 1)) bad_er++;
        check("er_pattern", bad_er, 0);
        check("tready_at_sfd", tr_idx, 7);
        check("frame_done_count", done_cnt, 1);
        check("frame_done_byte", done_byte, fcs[31:24]);
        check("underflow_count", uf_cnt, 0);
        check("ifg_cycles", ifg_meas, (v.ifg == 0) ? 1 : v.ifg);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int cyc, er_sum;
        //         len base   pad tuser corr ifg exp_dv hand fcs
        vecs[0] = '{9,  8'h31, 0, 0, 0, 12, 21, 1, 32'hCBF43926};
        vecs[1] = '{10, 8'h01, 1, 0, 0, 5,  72, 0, 32'h0};
        vecs[2] = '{9,  8'h31, 0, 1, 0, 0,  21, 1, 32'hCBF43926};
        vecs[3] = '{9,  8'h31, 0, 0, 1, 3,  21, 1, 32'hCBF43927};
        vecs[4] = '{64, 8'h31, 0, 0, 0, 7,  76, 0, 32'h0};
        vecs[5] = '{60, 8'h80, 1, 0, 0, 1,  72, 0, 32'h0};
        vecs[6] = '{9,  8'h31, 1, 1, 1, 2,  72, 0, 32'h0};

        mon_clear();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_outputs_np", int'({np_rxd, np_dv, np_er, if_np.tready, np_busy, np_done, np_uf}), 0);
        check("reset_outputs_p", int'({p_rxd, p_dv, p_er, if_p.tready, p_busy, p_done, p_uf}), 0);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) run_frame(vecs[k], 1'b1);

        // Mid-frame underflow: stall after 5 accepted bytes.
        do_reset();
        sel = 1'b0;
        cfg_ifg = 8'd2;
        mon_clear();
        send_frame(10, 8'h01, 1'b0, 5, -1);
        idle_inputs();
        cyc = 0;
        while (m_busy && cyc < 3000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("uf_timeout", int'(cyc < 3000), 1);
        check("uf_dv_cycles", cap_d.size(), 14);
        check("uf_err_byte", (cap_d.size() == 14) ? int'(cap_d[13]) : -1, 0);
        check("uf_err_flag", (cap_er.size() == 14) ? int'(cap_er[13]) : -1, 1);
        er_sum = 0;
        foreach (cap_er[i]) er_sum += int'(cap_er[i]);
        check("uf_er_total", er_sum, 1);
        check("uf_pulses", uf_cnt, 1);
        check("uf_no_frame_done", done_cnt, 0);

        // Two queued 64-byte frames with cfg_ifg=0.
        do_reset();
        sel = 1'b0;
        cfg_ifg = 8'd0;
        mon_clear();
        send_frame(64, 8'h31, 1'b0, -1, -1);
        send_frame(64, 8'h40, 1'b0, -1, -1);
        idle_inputs();
        cyc = 0;
        while ((done_cnt < 2 || in_ifg || m_busy) && cyc < 3000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("b2b_timeout", int'(cyc < 3000), 1);
        check("b2b_gap", (gaps.size() > 0) ? gaps[0] : -1, 2);
        check("b2b_dv_cycles", cap_d.size(), 152);
        check("b2b_frames", done_cnt, 2);
        check("b2b_second_sfd", (cap_d.size() > 83) ? int'(cap_d[83]) : -1, 8'hD5);

        // Reset on payload byte 20, then a fresh frame without another reset.
        do_reset();
        sel = 1'b0;
        cfg_ifg = 8'd3;
        mon_clear();
        send_frame(64, 8'h31, 1'b0, -1, 20);
        #1;
        check("rst_bytes_before", cap_d.size(), 28);
        check("rst_byte20", int'(np_rxd), 8'h44);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_outputs", int'({np_rxd, np_dv, np_er, if_np.tready, np_busy, np_done, np_uf}), 0);
        rst = 1'b0;
        run_frame(vecs[0], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
